// File: rtl/signed_seq_multiplier.sv
// Sequential signed multiplier: magnitude shift-and-add, one multiplier bit per clock, then a sign-fix cycle.
// Define SIGNED_MULT_EARLY_EXIT_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module signed_seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             neg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             run_last;

    // The most negative value negates to itself, which read unsigned is exactly its magnitude.
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

`ifdef SIGNED_MULT_EARLY_EXIT_EN
    assign run_last = (count == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign run_last = (count == CW'(WIDTH - 1));
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        count  <= '0;
                        neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                    end
                end
                RUN: begin
                    // Magnitudes never exceed 2^(WIDTH-1), so the sum cannot carry out of PW bits.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                FIX: begin
                    product <= neg ? -acc : acc;
                    done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Randomized and directed bench for signed_seq_multiplier at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_signed_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [7:0] prod4;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [15:0] prod8;

    int vectors = 0;
    int miscompares = 0;

    signed_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    signed_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_product(int w, int a, int b);
        logic [15:0] r;
        r = 16'(a * b);
        if (w == 4) r[15:8] = 8'h00;
        return r;
    endfunction

    // Edges from the accepting edge to the edge after which done is visible.
    function automatic int model_latency(int w, int b);
        int m;
        int n;
        m = (b < 0) ? -b : b;
`ifdef SIGNED_MULT_EARLY_EXIT_EN
        n = 0;
        while (m != 0) begin
            n++;
            m = m >>> 1;
        end
        if (n == 0) n = 1;
`else
        n = w;
`endif
        return n + 1;
    endfunction

    function automatic int sx(int r, int w);
        int v;
        v = r % (1 << w);
        if (v >= (1 << (w - 1))) v = v - (1 << w);
        return v;
    endfunction

    // ---------------- DUT access ----------------
    function automatic logic [15:0] cur_prod(int sel);
        return (sel != 0) ? prod8 : {8'h00, prod4};
    endfunction

    function automatic logic cur_busy(int sel);
        return (sel != 0) ? busy8 : busy4;
    endfunction

    function automatic logic cur_done(int sel);
        return (sel != 0) ? done8 : done4;
    endfunction

    task automatic drive(input int sel, input bit st, input int a, input int b);
        if (sel != 0) begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start4 = st; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    // Issues one operation from the current (post-edge) time and measures it; no checking here.
    task automatic run_op(input int sel, input int a, input int b, input int n_spam,
                          output logic [15:0] prod, output int lat,
                          output bit busy_ok, output bit held_ok);
        logic [15:0] p0;
        p0 = cur_prod(sel);
        drive(sel, 1'b1, a, b);
        @(posedge clk); #1;
        drive(sel, n_spam > 0, int'($urandom), int'($urandom));
        busy_ok = cur_busy(sel);
        held_ok = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i >= n_spam) drive(sel, 1'b0, int'($urandom), int'($urandom));
            if (cur_done(sel)) begin
                lat = i;
                if (cur_busy(sel)) busy_ok = 1'b0;
                break;
            end
            if (!cur_busy(sel)) busy_ok = 1'b0;
            if (cur_prod(sel) !== p0) held_ok = 1'b0;
        end
        prod = cur_prod(sel);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy4 !== 1'b0)  begin miscompares++; $display("FAIL reset_busy4 got %b exp 0", busy4); end
        vectors++; if (done4 !== 1'b0)  begin miscompares++; $display("FAIL reset_done4 got %b exp 0", done4); end
        vectors++; if (prod4 !== 8'h00) begin miscompares++; $display("FAIL reset_prod4 got %h exp 00", prod4); end
        vectors++; if (busy8 !== 1'b0)  begin miscompares++; $display("FAIL reset_busy8 got %b exp 0", busy8); end
        vectors++; if (done8 !== 1'b0)  begin miscompares++; $display("FAIL reset_done8 got %b exp 0", done8); end
        vectors++; if (prod8 !== 16'h0) begin miscompares++; $display("FAIL reset_prod8 got %h exp 0000", prod8); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        int ta[9] = '{3, -3, 7, -8, 0, 7, 5, 3, -1};
        int tb_[9] = '{5, 5, -8, -8, -5, 1, 0, -8, -1};
        logic [15:0] p;
        int lat;
        bit bok, hok;
        for (int i = 0; i < 9; i++) begin
            run_op(0, ta[i], tb_[i], 0, p, lat, bok, hok);
            vectors++;
            if (p !== model_product(4, ta[i], tb_[i])) begin
                miscompares++;
                $display("FAIL dir_prod %0d*%0d got %h exp %h", ta[i], tb_[i], p, model_product(4, ta[i], tb_[i]));
            end
            vectors++;
            if (lat !== model_latency(4, tb_[i])) begin
                miscompares++;
                $display("FAIL dir_latency %0d*%0d got %0d exp %0d", ta[i], tb_[i], lat, model_latency(4, tb_[i]));
            end
            vectors++;
            if (bok !== 1'b1) begin miscompares++; $display("FAIL dir_busy %0d*%0d got %b exp 1", ta[i], tb_[i], bok); end
            vectors++;
            if (hok !== 1'b1) begin miscompares++; $display("FAIL dir_held %0d*%0d got %b exp 1", ta[i], tb_[i], hok); end
            @(posedge clk); #1;
            vectors++;
            if (done4 !== 1'b0) begin miscompares++; $display("FAIL dir_done_pulse got %b exp 0", done4); end
            vectors++;
            if (prod4 !== model_product(4, ta[i], tb_[i]) % 256) begin
                miscompares++; $display("FAIL dir_prod_hold got %h exp %h", prod4, model_product(4, ta[i], tb_[i]));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] p1, p2;
        int l1, l2;
        bit b1, b2, h1, h2;
        run_op(0, 2, 3, 0, p1, l1, b1, h1);
        run_op(0, 4, -4, 0, p2, l2, b2, h2);
        vectors++; if (p1 !== model_product(4, 2, 3))  begin miscompares++; $display("FAIL b2b_first got %h exp %h", p1, model_product(4, 2, 3)); end
        vectors++; if (p2 !== model_product(4, 4, -4)) begin miscompares++; $display("FAIL b2b_second got %h exp %h", p2, model_product(4, 4, -4)); end
        vectors++; if (l2 !== model_latency(4, -4))    begin miscompares++; $display("FAIL b2b_latency got %0d exp %0d", l2, model_latency(4, -4)); end
        vectors++; if (h2 !== 1'b1)                    begin miscompares++; $display("FAIL b2b_held got %b exp 1", h2); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_during_busy;
        logic [15:0] p;
        int lat;
        bit bok, hok;
        run_op(0, 5, -3, model_latency(4, -3) - 1, p, lat, bok, hok);
        vectors++; if (p !== model_product(4, 5, -3))  begin miscompares++; $display("FAIL spam_prod got %h exp %h", p, model_product(4, 5, -3)); end
        vectors++; if (lat !== model_latency(4, -3))   begin miscompares++; $display("FAIL spam_latency got %0d exp %0d", lat, model_latency(4, -3)); end
        @(posedge clk); #1;
        vectors++; if (busy4 !== 1'b0) begin miscompares++; $display("FAIL spam_no_new_op got busy %b exp 0", busy4); end
        vectors++; if (done4 !== 1'b0) begin miscompares++; $display("FAIL spam_no_done got %b exp 0", done4); end
    endtask

    task automatic test_reset_mid_op;
        int done_seen;
        logic [15:0] p;
        int lat;
        bit bok, hok;
        drive(0, 1'b1, 7, 7);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (prod4 !== 8'h00) begin miscompares++; $display("FAIL midrst_prod got %h exp 00", prod4); end
        vectors++; if (busy4 !== 1'b0)  begin miscompares++; $display("FAIL midrst_busy got %b exp 0", busy4); end
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4 === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL midrst_no_done got %0d pulses exp 0", done_seen); end
        run_op(0, 1, 1, 0, p, lat, bok, hok);
        vectors++; if (p !== model_product(4, 1, 1)) begin miscompares++; $display("FAIL midrst_next_prod got %h exp %h", p, model_product(4, 1, 1)); end
        vectors++; if (lat !== model_latency(4, 1))  begin miscompares++; $display("FAIL midrst_next_latency got %0d exp %0d", lat, model_latency(4, 1)); end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int sel, input int n);
        int w, a, b, lat;
        logic [15:0] p;
        bit bok, hok;
        w = (sel != 0) ? 8 : 4;
        for (int i = 0; i < n; i++) begin
            a = sx(int'($urandom_range(0, (1 << w) - 1)), w);
            b = sx(int'($urandom_range(0, (1 << w) - 1)), w);
            run_op(sel, a, b, 0, p, lat, bok, hok);
            vectors++;
            if (p !== model_product(w, a, b)) begin
                miscompares++; $display("FAIL rand_w%0d_prod %0d*%0d got %h exp %h", w, a, b, p, model_product(w, a, b));
            end
            vectors++;
            if (lat !== model_latency(w, b)) begin
                miscompares++; $display("FAIL rand_w%0d_latency %0d*%0d got %0d exp %0d", w, a, b, lat, model_latency(w, b));
            end
            vectors++;
            if (bok !== 1'b1 || hok !== 1'b1) begin
                miscompares++; $display("FAIL rand_w%0d_busy_held got %b%b exp 11", w, bok, hok);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_width8;
        int ta[3] = '{-128, 127, -128};
        int tb_[3] = '{-128, -128, 1};
        logic [15:0] p;
        int lat;
        bit bok, hok;
        for (int i = 0; i < 3; i++) begin
            run_op(1, ta[i], tb_[i], 0, p, lat, bok, hok);
            vectors++;
            if (p !== model_product(8, ta[i], tb_[i])) begin
                miscompares++; $display("FAIL w8_prod %0d*%0d got %h exp %h", ta[i], tb_[i], p, model_product(8, ta[i], tb_[i]));
            end
            vectors++;
            if (lat !== model_latency(8, tb_[i])) begin
                miscompares++; $display("FAIL w8_latency %0d*%0d got %0d exp %0d", ta[i], tb_[i], lat, model_latency(8, tb_[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        #1;
        test_reset;
        test_directed;
        test_back_to_back;
        test_start_during_busy;
        test_reset_mid_op;
        test_random(0, 40);
        test_width8;
        test_random(1, 20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signed_seq_multiplier.md
# signed_seq_multiplier

Parametrised sequential signed multiplier: shift-and-add over operand magnitudes, one multiplier bit per clock, with a final sign-fix cycle. It is the WIDTH-generic successor of the fixed 4-bit multiply datapath. It sits beside the adder/divider units behind the calculator's start/done operation handshake. It adds a busy flag, a single-cycle done pulse, a held result, back-to-back issue and optional early termination.

## Interface
- WIDTH, default 4: operand width in bits, two's complement, minimum 2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  multiplicand, signed; sampled on the accepting edge only.
- b  in  WIDTH  multiplier, signed; sampled on the accepting edge only.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: product valid.
- product  out  2*WIDTH  signed result; held until the next completion.

## Operation
- FSM has three states: IDLE, RUN and FIX.
- **IDLE**: start=1 is accepted on a clk edge.
  - Capture mag_a=|a| and mag_b=|b| as WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
  - Capture neg=a[WIDTH-1]^b[WIDTH-1].
  - Clear acc (2*WIDTH bits). Load mcand={WIDTH zeros, mag_a} and mplier=mag_b.
  - Go to RUN; busy=1.
- **RUN**, each cycle:
  - If mplier[0]=1, acc <= acc + mcand (unsigned, 2*WIDTH bits, no carry-out possible).
  - mcand <<= 1; mplier >>= 1; count += 1.
  - Go to FIX after WIDTH RUN cycles (see Configuration for early exit).
- **FIX**:
  - product <= neg ? -acc : acc, computed as two's complement in 2*WIDTH bits.
  - A zero result is never negative: -0 = 0.
  - done <= 1 for one cycle; busy <= 0; go to IDLE.
- Arithmetic range: the full product always fits. The extreme case is (-2^(W-1))^2 = 2^(2W-2) < 2^(2W-1); no saturation logic exists.
- start while busy is ignored and has no effect on the operation in flight.
- a and b are not required to stay stable after the accepting edge.
- Reset, including mid-operation:
  - state=IDLE, busy=0, done=0, product=0; acc, mcand, mplier and count cleared.
  - The in-flight operation is discarded and no done is produced.

## Timing
- start accepted at edge k:
  - busy=1 from after edge k.
  - RUN occupies edges k+1 … k+N.
  - FIX at edge k+N+1, after which product is updated, done=1 and busy=0.
  - done falls after edge k+N+2.
- N=WIDTH without early exit, so latency is WIDTH+1 edges from the accepting edge (5 for WIDTH=4).
- Back-to-back: start high in the done cycle is accepted, giving throughput of one result per N+2 cycles.
- product changes only at the FIX edge or on reset. It is stable between done pulses.
- done and busy are never high in the same cycle.

## Configuration
- Macro: SIGNED_MULT_EARLY_EXIT_EN.
- Defined:
  - RUN exits to FIX on the cycle whose post-shift mplier equals zero.
  - N = (index of MSB of mag_b)+1, with a minimum of 1 for mag_b=0.
  - The result is identical to the non-early-exit result.
- Undefined: N=WIDTH always, giving fixed latency. count alone terminates RUN and no zero-detect logic is built.

## Test plan
- WIDTH=4: a=3, b=5, start pulse -> done exactly 5 edges after accept, product=8'h0F; busy high for the 4 RUN cycles plus FIX edge window.
- WIDTH=4 sign cases:
  - -3×5 -> 8'hF1.
  - 7×-8 -> 8'hC8.
  - -8×-8 -> 8'h40.
  - 0×-5 -> 8'h00, never 8'h00 with neg artefacts.
- Back-to-back, and start during busy:
  - Issue 2×3, then raise start in the done cycle with 4×-4 -> products 8'h06 then 8'hF0.
  - Extra start pulses during busy are ignored.
- Reset mid-operation: accept 7×7, assert rst for 1 cycle after 2 RUN cycles -> product=0, busy=0, no done. A following 1×1 yields 8'h01 at normal latency.
- WIDTH=8: -128×-128 -> 16'h4000; 127×-128 -> 16'hC080; latency 9 edges.
- SIGNED_MULT_EARLY_EXIT_EN defined, WIDTH=4:
  - 7×1 -> product 8'h07, done 2 edges after accept.
  - 5×0 -> 8'h00, 2 edges.
  - 3×-8 -> 8'hE8, 5 edges.
  - Without the macro, all three take 5 edges.
